spi_slave_trx_one_char: RTL and testbench
=========================================

Name: spi_slave_trx_one_char

Overview:
- SPI target-side (slave) single-character transceiver; the opposite end of the team's SPI master character engine.
- Receives SCK, CS_N and MOSI from an external master, drives MISO, and exchanges one character of 1..16 bits per frame slot.
- Fully synchronous to S_SYSCLK: all SPI inputs are oversampled, and no logic is clocked from SCK.
- Sits between the SPI pins and the slave register/FIFO layer.

Parameters:
- CHAR_NBITS, 16, maximum character width in bits (shift/holding register width).

Ports:
- S_SYSCLK  in  1  platform clock.
- S_RESETN  in  1  asynchronous active-low reset.
- S_ENABLE  in  1  block enable; 0 forces IDLE.
- S_CPOL  in  1  SCK idle level.
- S_CPHA  in  1  0: sample on leading edge; 1: sample on trailing edge.
- S_REV  in  1  1: MSB first; 0: LSB first.
- S_CHAR_LEN  in  4  character length minus 1 (bits = S_CHAR_LEN+1).
- S_SPI_SCK  in  1  master clock.
- S_SPI_CS_N  in  1  chip select, active low.
- S_SPI_MOSI  in  1  serial data in.
- S_SPI_MISO  out  1  serial data out.
- S_SPI_MISO_OE  out  1  MISO tri-state enable.
- S_WCHAR  in  CHAR_NBITS  transmit character, right-justified.
- S_WCHAR_VALID  in  1  transmit character offered.
- S_WCHAR_READY  out  1  holding register empty.
- S_RCHAR  out  CHAR_NBITS  last received character, right-justified, upper bits 0.
- S_CHAR_DONE  out  1  one-cycle pulse, character complete.
- S_TX_UNDERRUN  out  1  one-cycle pulse, frame started with empty holding register.

Behaviour:
- Reset values: MISO=1, MISO_OE=0, WCHAR_READY=1, RCHAR=0, CHAR_DONE=0, TX_UNDERRUN=0, bit counter=0, state IDLE, holding register empty.
- Input sync: SCK, CS_N and MOSI each pass through 2-flop synchronizers; edges are detected on the synchronized SCK. Supported SCK frequency is at most S_SYSCLK/8.
- Leading edge: SCK leaves the S_CPOL level. Trailing edge: SCK returns to the S_CPOL level.
- Holding-register handshake: a load occurs when VALID&READY. READY drops the following cycle and rises again the cycle after the holding register transfers to the shift register.
- State IDLE:
  - MISO_OE=0.
  - Synchronized CS_N falling with S_ENABLE=1 -> LOAD.
- State LOAD (1 cycle):
  - shift_tx <= holding register, or all-ones if the holding register is empty; in the empty case TX_UNDERRUN pulses.
  - bit_cnt <= S_CHAR_LEN; MISO_OE=1; first bit driven on MISO.
  - -> ACTIVE.
- State ACTIVE:
  - Sample edge: capture MOSI into shift_rx at the bit position selected by S_REV.
  - Shift edge: advance MISO to the next bit.
  - CPHA=0: leading = sample, trailing = shift.
  - CPHA=1: leading = shift, trailing = sample. The first leading edge of a frame in CPHA=1 drives bit 0 again rather than shifting.
  - On the sample edge with bit_cnt==0: RCHAR <= assembled char (bits above S_CHAR_LEN zeroed) and CHAR_DONE pulses, both one cycle after that edge is detected.
  - Character boundary is the edge following the final sample: the trailing edge for CPHA=0, the next leading edge for CPHA=1. At that edge, reload shift_tx from the holding register (same underrun rule) and reset bit_cnt, giving back-to-back characters while CS_N stays low.
  - CS_N rising -> IDLE. If bit_cnt has not completed: partial data is discarded, no DONE pulse, and the holding register is not consumed.
- Bit order: REV=1 transmits bit[S_CHAR_LEN] first and receives MSB-aligned to bit[S_CHAR_LEN]. REV=0 transmits bit[0] first.
- Config latching: S_CPOL, S_CPHA, S_REV and S_CHAR_LEN are latched in LOAD. Changes mid-frame are ignored.
- Simultaneous VALID load and boundary transfer in the same cycle: the transfer takes the old holding contents, and the new value lands in the now-empty holding register.
- S_ENABLE=0: immediate -> IDLE, MISO_OE=0; the holding register is retained.
- Reset mid-frame: all state returns to reset values; the frame is lost.

Test Plan:
- Mode 0, LEN=7, REV=1, WCHAR=0xA5 preloaded; master sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; RCHAR=0x003C; exactly one DONE pulse; READY rises after LOAD.
- Mode 3, LEN=15, REV=0, WCHAR=0x1234; master sends 0xBEEF -> master receives 0x1234; RCHAR=0xBEEF; DONE once.
- Two characters with CS held low: WCHAR=0x11 then 0x22 supplied via handshake -> master reads 0x11, 0x22; two DONE pulses; no underrun.
- Frame started with empty holding register, mode 1 -> TX_UNDERRUN pulse; MISO all-ones; RCHAR still captured correctly.
- CS_N raised after 4 of 8 SCK periods -> no DONE; RCHAR unchanged; MISO_OE=0 within 3 cycles; next full frame correct.
- S_RESETN asserted mid-frame -> all outputs at reset values immediately; a subsequent mode 2 frame with 0x5A is received correctly.

Source files
------------

// File: rtl/spi_slave_trx_one_char.sv
// SPI slave single-character transceiver: oversamples SCK/CS_N/MOSI on S_SYSCLK and
// exchanges one 1..16-bit character per slot, back-to-back while CS_N stays low.
module spi_slave_trx_one_char #(
  parameter int CHAR_NBITS = 16
) (
  input  logic                  S_SYSCLK,
  input  logic                  S_RESETN,
  input  logic                  S_ENABLE,
  input  logic                  S_CPOL,
  input  logic                  S_CPHA,
  input  logic                  S_REV,
  input  logic [3:0]            S_CHAR_LEN,
  input  logic                  S_SPI_SCK,
  input  logic                  S_SPI_CS_N,
  input  logic                  S_SPI_MOSI,
  output logic                  S_SPI_MISO,
  output logic                  S_SPI_MISO_OE,
  input  logic [CHAR_NBITS-1:0] S_WCHAR,
  input  logic                  S_WCHAR_VALID,
  output logic                  S_WCHAR_READY,
  output logic [CHAR_NBITS-1:0] S_RCHAR,
  output logic                  S_CHAR_DONE,
  output logic                  S_TX_UNDERRUN
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ACTIVE
  } state_t;

  state_t state_q, state_d;

  // Synchronizers plus one extra stage on SCK and CS_N for edge detection.
  logic [1:0] sck_sync, cs_sync, mosi_sync;
  logic       sck_d, cs_d;
  logic       sck_s, cs_s, mosi_s;

  // Frame configuration, frozen for the whole frame.
  logic       cpol_q, cpha_q, rev_q;
  logic [3:0] len_q;

  logic [3:0]            bit_cnt;
  logic                  bit_sampled;
  logic [CHAR_NBITS-1:0] shift_tx, shift_rx, rx_word;
  logic [CHAR_NBITS-1:0] hold_data, tx_src;
  logic                  hold_full;
  logic                  miso_q;
  logic [CHAR_NBITS-1:0] rchar_q;
  logic                  char_done_q, underrun_q;

  logic sck_rise, sck_fall, lead_edge, trail_edge;
  logic active, load_evt, sample_evt, shift_evt, boundary, transfer;
  logic [3:0] cur_pos;

  // Frame-order bit index -> character bit position.
  function automatic logic [3:0] bit_pos(input logic rev, input logic [3:0] len,
                                         input logic [3:0] cnt);
    return rev ? cnt : len - cnt;
  endfunction

  function automatic logic tx_bit(input logic [CHAR_NBITS-1:0] word, input logic rev,
                                  input logic [3:0] len, input logic [3:0] cnt);
    return word[bit_pos(rev, len, cnt)];
  endfunction

  // NOTE: every flop is updated with <= so all registers see pre-edge values in the same cycle.
  always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
    if (!S_RESETN) begin
      sck_sync  <= 2'b00;
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[0], S_SPI_SCK};
      cs_sync   <= {cs_sync[0], S_SPI_CS_N};
      mosi_sync <= {mosi_sync[0], S_SPI_MOSI};
      sck_d     <= sck_sync[1];
      cs_d      <= cs_sync[1];
    end
  end

  assign sck_s  = sck_sync[1];
  assign cs_s   = cs_sync[1];
  assign mosi_s = mosi_sync[1];

  assign sck_rise   = sck_s & ~sck_d;
  assign sck_fall   = ~sck_s & sck_d;
  assign lead_edge  = cpol_q ? sck_fall : sck_rise;
  assign trail_edge = cpol_q ? sck_rise : sck_fall;

  assign active     = (state_q == ST_ACTIVE) & S_ENABLE & ~cs_s;
  assign load_evt   = (state_q == ST_LOAD) & S_ENABLE & ~cs_s;
  assign sample_evt = active & (cpha_q ? trail_edge : lead_edge);
  assign shift_evt  = active & (cpha_q ? lead_edge : trail_edge);
  // A shift edge only advances once the current bit was sampled; this also makes the
  // first CPHA=1 leading edge a no-op that keeps bit 0 on MISO.
  assign boundary   = shift_evt & bit_sampled & (bit_cnt == 4'd0);
  assign transfer   = load_evt | boundary;

  assign tx_src  = hold_full ? hold_data : '1;
  assign cur_pos = bit_pos(rev_q, len_q, bit_cnt);

  always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
    if (!S_RESETN) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // NOTE: default assigned first so no path leaves state_d unassigned (no latch).
  always_comb begin
    state_d = state_q;
    if (!S_ENABLE) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (cs_d & ~cs_s) state_d = ST_LOAD;
        ST_LOAD:   state_d = cs_s ? ST_IDLE : ST_ACTIVE;
        ST_ACTIVE: if (cs_s) state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Receive word including the bit being sampled now, bits above the length cleared.
  always_comb begin
    rx_word          = shift_rx;
    rx_word[cur_pos] = mosi_s;
    for (int i = 0; i < CHAR_NBITS; i++) begin
      if (i > int'(len_q)) rx_word[i] = 1'b0;
    end
  end

  // Holding register: a transfer takes the old contents, a same-cycle load refills it.
  always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
    if (!S_RESETN) begin
      hold_data <= '0;
      hold_full <= 1'b0;
    end else if (S_WCHAR_VALID && !hold_full) begin
      hold_data <= S_WCHAR;
      hold_full <= 1'b1;
    end else if (transfer) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge S_SYSCLK or negedge S_RESETN) begin
    if (!S_RESETN) begin
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      rev_q       <= 1'b0;
      len_q       <= 4'd0;
      bit_cnt     <= 4'd0;
      bit_sampled <= 1'b0;
      shift_tx    <= '0;
      shift_rx    <= '0;
      miso_q      <= 1'b1;
      rchar_q     <= '0;
      char_done_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      char_done_q <= 1'b0;
      underrun_q  <= 1'b0;

      if (transfer) begin
        shift_tx   <= tx_src;
        underrun_q <= ~hold_full;
      end

      if (load_evt) begin
        cpol_q      <= S_CPOL;
        cpha_q      <= S_CPHA;
        rev_q       <= S_REV;
        len_q       <= S_CHAR_LEN;
        bit_cnt     <= S_CHAR_LEN;
        bit_sampled <= 1'b0;
        miso_q      <= tx_bit(tx_src, S_REV, S_CHAR_LEN, S_CHAR_LEN);
      end else if (sample_evt) begin
        shift_rx    <= rx_word;
        bit_sampled <= 1'b1;
        if (bit_cnt == 4'd0) begin
          rchar_q     <= rx_word;
          char_done_q <= 1'b1;
        end
      end else if (shift_evt && bit_sampled) begin
        bit_sampled <= 1'b0;
        if (bit_cnt == 4'd0) begin
          bit_cnt <= len_q;
          miso_q  <= tx_bit(tx_src, rev_q, len_q, len_q);
        end else begin
          bit_cnt <= bit_cnt - 4'd1;
          miso_q  <= tx_bit(shift_tx, rev_q, len_q, bit_cnt - 4'd1);
        end
      end else if (state_q == ST_IDLE) begin
        miso_q <= 1'b1;
      end
    end
  end

  assign S_SPI_MISO    = miso_q;
  assign S_SPI_MISO_OE = S_ENABLE & (state_q != ST_IDLE);
  assign S_WCHAR_READY = ~hold_full;
  assign S_RCHAR       = rchar_q;
  assign S_CHAR_DONE   = char_done_q;
  assign S_TX_UNDERRUN = underrun_q;

endmodule

// File: tb/tb_spi_slave_trx_one_char.sv
// Bench for spi_slave_trx_one_char: a bit-banged SPI master drives frames; directed table,
// hand-written corner sequences and randomized frames checked against a word-level model.
module tb_spi_slave_trx_one_char;

  localparam int H = 8;  // SCK half period in system clocks

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, cpol_i, cpha_i, rev_i;
  logic [3:0]  len_i;
  logic        sck, cs_n, mosi;
  logic        miso, miso_oe;
  logic [15:0] wchar;
  logic        wvalid, wready;
  logic [15:0] rchar;
  logic        done, underrun;

  always #5 clk = ~clk;

  spi_slave_trx_one_char #(.CHAR_NBITS(16)) dut (
    .S_SYSCLK      (clk),
    .S_RESETN      (rst_n),
    .S_ENABLE      (enable),
    .S_CPOL        (cpol_i),
    .S_CPHA        (cpha_i),
    .S_REV         (rev_i),
    .S_CHAR_LEN    (len_i),
    .S_SPI_SCK     (sck),
    .S_SPI_CS_N    (cs_n),
    .S_SPI_MOSI    (mosi),
    .S_SPI_MISO    (miso),
    .S_SPI_MISO_OE (miso_oe),
    .S_WCHAR       (wchar),
    .S_WCHAR_VALID (wvalid),
    .S_WCHAR_READY (wready),
    .S_RCHAR       (rchar),
    .S_CHAR_DONE   (done),
    .S_TX_UNDERRUN (underrun)
  );

  int   n_tests = 0, n_fail = 0;
  int   done_total = 0, ur_total = 0;
  logic oe_after_cs;

  always @(negedge clk) begin
    if (done)     done_total++;
    if (underrun) ur_total++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mask16(input logic [3:0] l);
    return 16'((32'd1 << (int'(l) + 1)) - 32'd1);
  endfunction

  task automatic half();
    repeat (H) @(negedge clk);
  endtask

  task automatic push_word(input logic [15:0] w);
    bit ok;
    ok = 0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (wready) begin
        wchar  = w;
        wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        ok     = 1;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL push_timeout: READY stayed 0, expected 1");
    end
  endtask

  // Bit-banged master. Words for characters after the first are offered during the
  // preceding character. abort_bits != 0 raises CS_N after that many bits.
  task automatic spi_frame(input logic c_pol, input logic c_pha, input logic r,
                           input logic [3:0] l, input int nchars,
                           input logic [1:0][15:0] mw, input logic [1:0][15:0] sw,
                           input int abort_bits, output logic [1:0][15:0] mrx);
    int nb;
    bit stop;
    int p;
    nb   = 0;
    stop = 0;
    mrx  = '0;
    cpol_i = c_pol; cpha_i = c_pha; rev_i = r; len_i = l;
    sck = c_pol;
    half();
    cs_n = 1'b0;
    half();
    // Config inputs change mid-frame; the slave must keep the values taken at frame start.
    {cpol_i, cpha_i, rev_i, len_i} = 7'($urandom);
    for (int c = 0; c < nchars && !stop; c++) begin
      for (int b = 0; b <= int'(l) && !stop; b++) begin
        p = r ? int'(l) - b : b;
        if (b == int'(l) && c + 1 < nchars) push_word(sw[c+1]);
        if (!c_pha) begin
          mosi = mw[c][p];
          half();
          sck = ~c_pol;
          mrx[c][p] = miso;
          half();
          sck = c_pol;
        end else begin
          sck  = ~c_pol;
          mosi = mw[c][p];
          half();
          sck = c_pol;
          mrx[c][p] = miso;
          half();
        end
        nb++;
        if (abort_bits != 0 && nb == abort_bits) stop = 1;
      end
    end
    half();
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
    oe_after_cs = miso_oe;
    half();
    half();
  endtask

  typedef struct {
    logic        cpol, cpha, rev;
    logic [3:0]  len;
    logic        preload;
    logic [15:0] sw, mw, exp_rx, exp_rchar;
    int          exp_ur;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0][15:0] mrx, mw_r, sw_r;
    int d0, u0;
    logic cp, ch, rv, pre;
    logic [3:0] l;
    logic [15:0] m;
    int nch, exp_ur;

    tbl[0] = '{1'b0, 1'b0, 1'b1, 4'd7,  1'b1, 16'h00A5, 16'h003C, 16'h00A5, 16'h003C, 1};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 4'd15, 1'b1, 16'h1234, 16'hBEEF, 16'h1234, 16'hBEEF, 0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 4'd7,  1'b0, 16'h0000, 16'h0096, 16'h00FF, 16'h0096, 1};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 4'd0,  1'b1, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 1};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 4'd4,  1'b1, 16'hFFEA, 16'hFFF5, 16'h000A, 16'h0015, 1};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 4'd11, 1'b1, 16'h0ABC, 16'h0F0F, 16'h0ABC, 16'h0F0F, 0};

    rst_n = 1'b0; enable = 1'b1; cpol_i = 0; cpha_i = 0; rev_i = 0; len_i = 4'd7;
    sck = 0; cs_n = 1; mosi = 0; wchar = '0; wvalid = 0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_miso", miso, 1);
    check("rst_oe", miso_oe, 0);
    check("rst_ready", wready, 1);
    check("rst_rchar", rchar, 0);
    check("rst_done", done, 0);
    check("rst_underrun", underrun, 0);

    // Directed table
    for (int i = 0; i < 6; i++) begin
      d0 = done_total; u0 = ur_total;
      if (tbl[i].preload) begin
        push_word(tbl[i].sw);
        check($sformatf("v%0d_ready_low", i), wready, 0);
      end
      spi_frame(tbl[i].cpol, tbl[i].cpha, tbl[i].rev, tbl[i].len, 1,
                {16'h0, tbl[i].mw}, {16'h0, tbl[i].sw}, 0, mrx);
      check($sformatf("v%0d_master_rx", i), mrx[0], tbl[i].exp_rx);
      check($sformatf("v%0d_rchar", i), rchar, tbl[i].exp_rchar);
      check($sformatf("v%0d_done", i), done_total - d0, 1);
      check($sformatf("v%0d_underrun", i), ur_total - u0, tbl[i].exp_ur);
      check($sformatf("v%0d_ready_high", i), wready, 1);
      check($sformatf("v%0d_oe_off", i), oe_after_cs, 0);
    end

    // Two characters back-to-back, second supplied by handshake mid-frame
    d0 = done_total; u0 = ur_total;
    push_word(16'h0011);
    spi_frame(1'b0, 1'b1, 1'b1, 4'd7, 2, {16'h00C3, 16'h005A}, {16'h0022, 16'h0011}, 0, mrx);
    check("b2b_rx0", mrx[0], 16'h0011);
    check("b2b_rx1", mrx[1], 16'h0022);
    check("b2b_rchar", rchar, 16'h00C3);
    check("b2b_done", done_total - d0, 2);
    check("b2b_underrun", ur_total - u0, 0);

    // Known frame, then aborted frame: RCHAR must keep 0x5A
    push_word(16'h0081);
    spi_frame(1'b0, 1'b0, 1'b1, 4'd7, 1, {16'h0, 16'h005A}, {16'h0, 16'h0081}, 0, mrx);
    check("pre_abort_rchar", rchar, 16'h005A);
    d0 = done_total; u0 = ur_total;
    push_word(16'h0077);
    spi_frame(1'b0, 1'b0, 1'b1, 4'd7, 1, {16'h0, 16'h00FF}, {16'h0, 16'h0077}, 4, mrx);
    check("abort_done", done_total - d0, 0);
    check("abort_rchar", rchar, 16'h005A);
    check("abort_oe_off", oe_after_cs, 0);
    check("abort_underrun", ur_total - u0, 0);
    d0 = done_total;
    push_word(16'h00C3);
    spi_frame(1'b0, 1'b0, 1'b1, 4'd7, 1, {16'h0, 16'h0096}, {16'h0, 16'h00C3}, 0, mrx);
    check("post_abort_rx", mrx[0], 16'h00C3);
    check("post_abort_rchar", rchar, 16'h0096);
    check("post_abort_done", done_total - d0, 1);

    // Disabled: CS_N falling is ignored and the holding register is kept
    enable = 1'b0;
    push_word(16'h0033);
    check("dis_ready_low", wready, 0);
    cs_n = 1'b0;
    half();
    check("dis_oe", miso_oe, 0);
    cs_n = 1'b1;
    half();
    enable = 1'b1;
    half();
    check("dis_hold_kept", wready, 0);
    u0 = ur_total;
    spi_frame(1'b0, 1'b1, 1'b1, 4'd7, 1, {16'h0, 16'h0044}, {16'h0, 16'h0}, 0, mrx);
    check("dis_then_rx", mrx[0], 16'h0033);
    check("dis_then_underrun", ur_total - u0, 0);

    // Reset mid-frame
    push_word(16'h000F);
    cpol_i = 0; cpha_i = 0; rev_i = 1; len_i = 4'd7; sck = 0;
    half();
    cs_n = 1'b0;
    half();
    for (int b = 0; b < 3; b++) begin
      mosi = 1'b1;
      half();
      sck = 1'b1;
      half();
      sck = 1'b0;
    end
    push_word(16'h0F0F);
    half();
    check("mid_ready_low", wready, 0);
    check("mid_miso_low", miso, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_miso", miso, 1);
    check("mrst_oe", miso_oe, 0);
    check("mrst_ready", wready, 1);
    check("mrst_rchar", rchar, 0);
    check("mrst_done", done, 0);
    check("mrst_underrun", underrun, 0);
    cs_n = 1'b1; mosi = 1'b0;
    half();
    rst_n = 1'b1;
    half();
    d0 = done_total;
    push_word(16'h003C);
    spi_frame(1'b1, 1'b0, 1'b1, 4'd7, 1, {16'h0, 16'h005A}, {16'h0, 16'h003C}, 0, mrx);
    check("mode2_rx", mrx[0], 16'h003C);
    check("mode2_rchar", rchar, 16'h005A);
    check("mode2_done", done_total - d0, 1);

    // Randomized frames against a word-level model
    for (int t = 0; t < 16; t++) begin
      cp  = 1'($urandom);
      ch  = 1'($urandom);
      rv  = 1'($urandom);
      pre = 1'($urandom);
      l   = 4'($urandom_range(0, 15));
      nch = $urandom_range(1, 2);
      mw_r = {16'($urandom), 16'($urandom)};
      sw_r = {16'($urandom), 16'($urandom)};
      d0 = done_total; u0 = ur_total;
      if (pre) push_word(sw_r[0]);
      spi_frame(cp, ch, rv, l, nch, mw_r, sw_r, 0, mrx);
      m = mask16(l);
      for (int c = 0; c < nch; c++)
        check($sformatf("rnd%0d_rx%0d", t, c), mrx[c], (c == 0 && !pre) ? m : (sw_r[c] & m));
      check($sformatf("rnd%0d_rchar", t), rchar, mw_r[nch-1] & m);
      check($sformatf("rnd%0d_done", t), done_total - d0, nch);
      // Empty LOAD underruns; CPHA=0 also reloads (from empty) on the final trailing edge.
      exp_ur = (pre ? 0 : 1) + (ch ? 0 : 1);
      check($sformatf("rnd%0d_underrun", t), ur_total - u0, exp_ur);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
